nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequential controller that drives a 4-bit carry-lookahead adder slice, which sits directly downstream of this block and is instantiated beside it.
- Accepts wide operands through a valid/ready handshake. Presents one nibble per cycle to the slice, LSB nibble first.
- Registers each slice sum and chains the slice carry-out into the next cycle's carry-in.
- Returns the full-width result, unsigned carry and signed overflow through a valid/ready output handshake. Supports add and subtract.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, operands and mode valid.
- in_ready, output, 1, block can accept operands.
- op_a, input, W, operand A.
- op_b, input, W, operand B.
- sub, input, 1, 0 = A+B, 1 = A-B (two's complement).
- cla_a, output, 4, current A nibble to the slice.
- cla_b, output, 4, current B nibble (inverted when subtracting) to the slice.
- cla_cin, output, 1, carry-in to the slice.
- cla_sum, input, 4, slice sum; combinational from cla_a/cla_b/cla_cin.
- cla_cout, input, 1, slice carry-out; combinational.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- result, output, W, sum or difference, modulo 2^W.
- carry_out, output, 1, final slice carry-out; for subtract, 1 means no borrow.
- overflow, output, 1, signed two's-complement overflow.

Behaviour:
- Reset:
  - Clock and reset are one clock (clk); reset (rst) is asynchronous and active-high.
  - While rst is high: state=IDLE; in_ready=1, out_valid=0, result=0, carry_out=0, overflow=0, cla_a=0, cla_b=0, cla_cin=0.
  - Internal index, carry and operand registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a and latch beff = sub ? ~op_b : op_b. Set carry register = sub. Set idx=0. Go to RUN.
- RUN (exactly NIBBLES cycles):
  - in_ready=0.
  - cla_a = A[4*idx+3:4*idx], cla_b = beff[4*idx+3:4*idx], cla_cin = carry register. All three are driven from registers, so they are glitch-free.
  - Each edge: result[4*idx+3:4*idx] <= cla_sum; carry register <= cla_cout; idx increments.
  - On the edge where idx = NIBBLES-1:
    - carry_out <= cla_cout.
    - overflow <= (A[W-1] == beff[W-1]) && (cla_sum[3] != A[W-1]).
    - Go to DONE.
- DONE:
  - out_valid=1. result, carry_out and overflow are held stable.
  - On out_valid&out_ready: out_valid drops and the state returns to IDLE.
  - The next op can therefore be accepted one cycle after the handshake; no skid.
- Latency: handshake at edge N gives out_valid high after edge N+NIBBLES+... exactly: RUN spans edges N+1..N+NIBBLES, and out_valid is high from edge N+NIBBLES onward.
- Throughput: one operation per NIBBLES+2 cycles with out_ready held high.
- cla_a/cla_b/cla_cin outside RUN: held at 0.
- Inputs are ignored outside IDLE. Operand changes after acceptance do not affect the result.
- result is not cleared between operations. Its value is defined only while out_valid=1.
- out_ready high outside DONE has no effect.
- Asynchronous reset during RUN or DONE aborts the operation immediately. All outputs take reset values; no partial result is presented.
- The slice's internal carry logic is trusted. This block does no arithmetic itself beyond the inversion and the overflow compare.

Test Plan:
- NIBBLES=4, add 16'h1234 + 16'h4321, out_ready=1 -> result=16'h5555, carry_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge; the slice sees cla_cin=0,0,0,0.
- Carry ripple across all slices: 16'hFFFF + 16'h0001 -> result=16'h0000, carry_out=1, overflow=0. cla_cin sequence 0,1,1,1.
- Subtract 16'h0005 - 16'h0007 -> result=16'hFFFE, carry_out=0 (borrow), overflow=0. Subtract 16'h8000 - 16'h0001 -> result=16'h7FFF, carry_out=1, overflow=1.
- Signed add overflow 16'h7FFF + 16'h0001 -> result=16'h8000, overflow=1, carry_out=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Result stays stable, in_ready stays 0, and a new in_valid is ignored. Raising out_ready gives one handshake, then in_ready=1 on the next cycle.
- Assert rst for 1 cycle mid-RUN (after 2 nibbles). Outputs go to reset values immediately, no out_valid occurs, and the next operation 16'h0F0F + 16'h00F1 -> 16'h1000 completes correctly.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Serial controller for an external 4-bit adder slice.
// It feeds one operand nibble per cycle, LSB nibble first, and collects the wide result.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         sub,
  output logic [3:0]   cla_a,
  output logic [3:0]   cla_b,
  output logic         cla_cin,
  input  logic [3:0]   cla_sum,
  input  logic         cla_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_shift;
  logic [W-1:0]  b_shift;
  logic          carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)    state_next = RUN;
      RUN:     if (idx == LAST) state_next = DONE;
      DONE:    if (out_ready)   state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Operands shift right one nibble per RUN cycle, so the low nibble is always the
  // current slice input and the registers have drained to zero once RUN ends.
  assign cla_a   = a_shift[3:0];
  assign cla_b   = b_shift[3:0];
  assign cla_cin = carry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_shift   <= '0;
      b_shift   <= '0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_shift <= op_a;
      b_shift <= sub ? ~op_b : op_b;
      carry   <= sub;
      idx     <= '0;
    end else if (state == RUN) begin
      a_shift <= a_shift >> 4;
      b_shift <= b_shift >> 4;
      idx     <= idx + 1'b1;
      for (int i = 0; i < NIBBLES; i++) begin
        if (idx == IW'(i)) result[4*i +: 4] <= cla_sum;
      end
      if (idx == LAST) begin
        // Top nibble is in the low bits here, so bit 3 is the operand sign.
        carry     <= 1'b0;
        carry_out <= cla_cout;
        overflow  <= (a_shift[3] == b_shift[3]) && (cla_sum[3] != a_shift[3]);
      end else begin
        carry <= cla_cout;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with a behavioural 4-bit slice beside it.
module tb_nibble_serial_adder_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic [3:0]   cla_a;
  logic [3:0]   cla_b;
  logic         cla_cin;
  logic [3:0]   cla_sum;
  logic         cla_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Adder slice sitting next to the controller
  assign {cla_cout, cla_sum} = {1'b0, cla_a} + {1'b0, cla_b} + {4'b0, cla_cin};

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check({tag, "_ready_wait"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic [15:0] er, input logic ec,
                       input logic ev, input logic [3:0] ecin, input bit stall);
    logic [3:0] cin_seq;
    logic       early;
    logic       stable;
    wait_ready(tag);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = !stall;
    tick;  // accept edge
    in_valid = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; sub = ~s;
    cin_seq = '0;
    early = 1'b0;
    for (int k = 0; k < NIBBLES; k++) begin
      early |= out_valid;
      cin_seq[k] = cla_cin;
      tick;
    end
    check({tag, "_early_valid"}, {31'b0, early}, 32'd0);
    check({tag, "_cin_seq"}, {28'b0, cin_seq}, {28'b0, ecin});
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_result"}, {16'b0, result}, {16'b0, er});
    check({tag, "_carry"}, {31'b0, carry_out}, {31'b0, ec});
    check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, ev});
    check({tag, "_slice_idle"}, {23'b0, cla_a, cla_b, cla_cin}, 32'd0);
    if (stall) begin
      stable = 1'b1;
      for (int k = 0; k < 5; k++) begin
        in_valid = 1'b1; op_a = 16'h1111 * (k + 1); op_b = 16'h0101; sub = 1'b0;
        tick;
        stable &= (result === er) && (out_valid === 1'b1) && (in_ready === 1'b0);
      end
      in_valid = 1'b0;
      check({tag, "_stall_hold"}, {31'b0, stable}, 32'd1);
      out_ready = 1'b1;
    end
    tick;  // handshake edge
    check({tag, "_post_hs"}, {30'b0, out_valid, in_ready}, 32'b01);
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [28:0] snap;
    logic        seen;
    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; out_ready = 1'b0;
    #1;
    snap = {in_ready, out_valid, result, carry_out, overflow, cla_a, cla_b, cla_cin};
    check("reset_state", {3'b0, snap}, {3'b0, 1'b1, 28'b0});
    tick; tick;
    rst = 1'b0;

    do_op("add_basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000, 1'b0);
    do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110, 1'b0);
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001, 1'b0);
    do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0001, 1'b0);
    do_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110, 1'b0);
    do_op("backpress",  16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0, 4'b0000, 1'b1);

    // Abort mid-RUN after two nibbles
    wait_ready("abort");
    op_a = 16'h1111; op_b = 16'h2222; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    tick; tick;
    #3 rst = 1'b1;
    #1;
    snap = {in_ready, out_valid, result, carry_out, overflow, cla_a, cla_b, cla_cin};
    check("abort_async", {3'b0, snap}, {3'b0, 1'b1, 28'b0});
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      seen |= out_valid;
      tick;
    end
    check("abort_no_valid", {31'b0, seen}, 32'd0);
    do_op("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 4'b1110, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
